uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// Decodes 0x55 0xA5 addr data_hi data_lo [checksum] byte frames into one register write each.
// Define UART_CMD_CHECKSUM_EN to add and verify the trailing checksum byte (6-byte frames).
module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data_byte,
    input  logic        rx_done,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] HDR1_BYTE = 8'h55;
    localparam logic [7:0] HDR2_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR2,
        ST_ADDR,
        ST_DHI,
`ifdef UART_CMD_CHECKSUM_EN
        ST_DLO,
        ST_CSUM
`else
        ST_DLO
`endif
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [7:0]         addr_sh_q,   addr_sh_d;
    logic [7:0]         dhi_sh_q,    dhi_sh_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]         dlo_sh_q,    dlo_sh_d;
    logic [7:0]         csum_calc;
`endif
    logic [7:0]         reg_addr_q,  reg_addr_d;
    logic [15:0]        reg_wdata_q, reg_wdata_d;
    logic               reg_wr_q,    reg_wr_d;
    logic               frame_err_q, frame_err_d;
    logic               timeout_hit;

`ifdef UART_CMD_CHECKSUM_EN
    // 8-bit sum wraps naturally, giving the mod-256 checksum.
    assign csum_calc = addr_sh_q + dhi_sh_q + dlo_sh_q;
`endif

    // A byte arriving on the threshold cycle takes priority over the timeout.
    assign timeout_hit = (state_q != ST_IDLE) && !rx_done && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        dhi_sh_d    = dhi_sh_q;
`ifdef UART_CMD_CHECKSUM_EN
        dlo_sh_d    = dlo_sh_q;
`endif
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        frame_err_d = 1'b0;

        if ((state_q == ST_IDLE) || rx_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (timeout_hit) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            cnt_d       = '0;
            addr_sh_d   = 8'h00;
            dhi_sh_d    = 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_sh_d    = 8'h00;
`endif
        end else if (rx_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (data_byte == HDR1_BYTE) begin
                        state_d = ST_HDR2;
                    end
                end
                ST_HDR2: begin
                    if (data_byte == HDR2_BYTE) begin
                        state_d = ST_ADDR;
                    end else if (data_byte != HDR1_BYTE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_sh_d = data_byte;
                    state_d   = ST_DHI;
                end
                ST_DHI: begin
                    dhi_sh_d = data_byte;
                    state_d  = ST_DLO;
                end
`ifdef UART_CMD_CHECKSUM_EN
                ST_DLO: begin
                    dlo_sh_d = data_byte;
                    state_d  = ST_CSUM;
                end
                ST_CSUM: begin
                    if (data_byte == csum_calc) begin
                        reg_addr_d  = addr_sh_q;
                        reg_wdata_d = {dhi_sh_q, dlo_sh_q};
                        reg_wr_d    = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
`else
                ST_DLO: begin
                    reg_addr_d  = addr_sh_q;
                    reg_wdata_d = {dhi_sh_q, data_byte};
                    reg_wr_d    = 1'b1;
                    state_d     = ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_sh_q   <= 8'h00;
            dhi_sh_q    <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_sh_q    <= 8'h00;
`endif
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 16'h0000;
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_sh_q   <= addr_sh_d;
            dhi_sh_q    <= dhi_sh_d;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_sh_q    <= dlo_sh_d;
`endif
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
